// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the memory access unit: mem_control bit positions,
// FSM state encoding, bus size codes and small decode helpers.
package mem_access_unit_pkg;

    localparam int CTRL_LB  = 7;
    localparam int CTRL_LBU = 6;
    localparam int CTRL_LH  = 5;
    localparam int CTRL_LHU = 4;
    localparam int CTRL_LW  = 3;
    localparam int CTRL_SB  = 2;
    localparam int CTRL_SH  = 1;
    localparam int CTRL_SW  = 0;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic is_onehot8(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

    function automatic logic [1:0] size_of(input logic [7:0] mc);
        if (mc[CTRL_LB] | mc[CTRL_LBU] | mc[CTRL_SB])
            return SIZE_BYTE;
        else if (mc[CTRL_LH] | mc[CTRL_LHU] | mc[CTRL_SH])
            return SIZE_HALF;
        else
            return SIZE_WORD;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load lane selection and sign/zero extension; purely combinational.
// Only the five load bits of mem_control are needed here.
module mem_access_unit_load_align
    import mem_access_unit_pkg::*;
(
    input  logic [7:3]  load_op,
    input  logic [1:0]  lane,
    input  logic [31:0] rdata,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (lane)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = lane[1] ? rdata[31:16] : rdata[15:0];

        result = '0;
        if (load_op[CTRL_LB])
            result = {{24{byte_sel[7]}}, byte_sel};
        else if (load_op[CTRL_LBU])
            result = {24'd0, byte_sel};
        else if (load_op[CTRL_LH])
            result = {{16{half_sel[15]}}, half_sel};
        else if (load_op[CTRL_LHU])
            result = {16'd0, half_sel};
        else if (load_op[CTRL_LW])
            result = rdata;
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit driving a req/addr_ok/data_ok data bus.
// Define MEM_UNALIGNED_EXC_EN to raise adel/ades instead of force-aligning.
module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [7:0]  mem_control,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        stall,
    output logic        result_valid,
    output logic [31:0] result_data,
    output logic        adel,
    output logic        ades
);

    state_t      state, state_next;
    logic [7:0]  op_q;
    logic        wr_q;
    logic [31:0] rdata_q;
    logic [31:0] load_result;

    logic        is_half, is_word, is_store, valid_op, exc_block, accept, capture;
    logic [31:0] addr_al;
    logic [3:0]  wstrb_c;
    logic [31:0] wdata_c;

    assign is_half  = mem_control[CTRL_LH] | mem_control[CTRL_LHU] | mem_control[CTRL_SH];
    assign is_word  = mem_control[CTRL_LW] | mem_control[CTRL_SW];
    assign is_store = mem_control[CTRL_SB] | mem_control[CTRL_SH] | mem_control[CTRL_SW];
    assign valid_op = !rst && (state == ST_IDLE) && valid_in && is_onehot8(mem_control);
    assign addr_al  = is_word ? {addr[31:2], 2'b00} :
                      is_half ? {addr[31:1], 1'b0}  : addr;

`ifdef MEM_UNALIGNED_EXC_EN
    logic misaligned;
    assign misaligned = (is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00));
    assign exc_block  = misaligned;
    assign adel       = valid_op & misaligned & !is_store;
    assign ades       = valid_op & misaligned & is_store;
`else
    assign exc_block  = 1'b0;
    assign adel       = 1'b0;
    assign ades       = 1'b0;
`endif

    assign accept  = valid_op & !exc_block;
    assign capture = ((state == ST_REQ) && data_addr_ok && data_data_ok) ||
                     ((state == ST_WAIT) && data_data_ok);

    always_comb begin
        wstrb_c = 4'b0000;
        wdata_c = wdata;
        if (mem_control[CTRL_SB]) begin
            wstrb_c = 4'b0001 << addr_al[1:0];
            wdata_c = {4{wdata[7:0]}};
        end else if (mem_control[CTRL_SH]) begin
            wstrb_c = addr_al[1] ? 4'b1100 : 4'b0011;
            wdata_c = {2{wdata[15:0]}};
        end else if (mem_control[CTRL_SW]) begin
            wstrb_c = 4'b1111;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = ST_REQ;
            ST_REQ: begin
                if (data_addr_ok && data_data_ok) state_next = ST_DONE;
                else if (data_addr_ok)            state_next = ST_WAIT;
            end
            ST_WAIT: if (data_data_ok) state_next = ST_DONE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            op_q       <= '0;
            wr_q       <= 1'b0;
            data_size  <= '0;
            data_addr  <= '0;
            data_wstrb <= '0;
            data_wdata <= '0;
            rdata_q    <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_q       <= mem_control;
                wr_q       <= is_store;
                data_size  <= size_of(mem_control);
                data_addr  <= addr_al;
                data_wstrb <= wstrb_c;
                data_wdata <= wdata_c;
            end
            if (capture)
                rdata_q <= data_rdata;
        end
    end

    mem_access_unit_load_align u_load_align (
        .load_op (op_q[7:3]),
        .lane    (data_addr[1:0]),
        .rdata   (rdata_q),
        .result  (load_result)
    );

    assign data_req     = (state == ST_REQ);
    assign data_wr      = data_req & wr_q;
    assign stall        = accept | (state == ST_REQ) | (state == ST_WAIT);
    assign result_valid = (state == ST_DONE);
    assign result_data  = (state == ST_DONE && !wr_q) ? load_result : 32'd0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit; inputs change and outputs
// are sampled around the falling edge, away from the active rising edge.
module tb_mem_access_unit;

    localparam logic [7:0] MC_LB  = 8'h80;
    localparam logic [7:0] MC_LBU = 8'h40;
    localparam logic [7:0] MC_LH  = 8'h20;
    localparam logic [7:0] MC_LHU = 8'h10;
    localparam logic [7:0] MC_LW  = 8'h08;
    localparam logic [7:0] MC_SB  = 8'h04;
    localparam logic [7:0] MC_SH  = 8'h02;
    localparam logic [7:0] MC_SW  = 8'h01;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [7:0]  mem_control;
    logic [31:0] addr, wdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        stall, result_valid, adel, ades;
    logic [31:0] result_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .mem_control(mem_control),
        .addr(addr), .wdata(wdata), .data_req(data_req), .data_wr(data_wr),
        .data_size(data_size), .data_addr(data_addr), .data_wstrb(data_wstrb),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata), .stall(stall),
        .result_valid(result_valid), .result_data(result_data),
        .adel(adel), .ades(ades)
    );

    task automatic next_cycle();
        @(negedge clk);
        valid_in     = 1'b0;
        mem_control  = 8'h00;
        addr         = 32'hFFFF_FFFF;
        wdata        = 32'hCCCC_CCCC;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = 32'h0BAD_0BAD;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        #1;
        checks++;
        if ({data_req, data_wr, stall, result_valid, adel, ades} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 000000",
                     {data_req, data_wr, stall, result_valid, adel, ades});
        end
        checks++;
        if ({data_size, data_addr, data_wstrb, data_wdata, result_data} !== '0) begin
            errors++;
            $display("FAIL reset_fields got size=%0d addr=%h wstrb=%b wdata=%h res=%h want all 0",
                     data_size, data_addr, data_wstrb, data_wdata, result_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_lw_latency();
        logic [5:0] stall_seen;
        logic [5:0] rv_seen;
        // cycle 0 accept, addr_ok at 2, data_ok at 4, DONE at 5
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            if (c == 0) begin valid_in = 1'b1; mem_control = MC_LW; addr = 32'h1000; end
            if (c == 2) data_addr_ok = 1'b1;
            if (c == 4) begin data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF; end
            #1;
            stall_seen[c] = stall;
            rv_seen[c]    = result_valid;
            if (c == 1) begin
                checks++;
                if ({data_req, data_wr, data_size, data_addr, data_wstrb} !== {1'b1, 1'b0, 2'd2, 32'h1000, 4'b0000}) begin
                    errors++;
                    $display("FAIL lw_request got req=%b wr=%b size=%0d addr=%h wstrb=%b want 1 0 2 00001000 0000",
                             data_req, data_wr, data_size, data_addr, data_wstrb);
                end
            end
            if (c == 3) begin
                checks++;
                if (data_req !== 1'b0) begin
                    errors++;
                    $display("FAIL lw_wait_req got %b want 0", data_req);
                end
            end
            if (c == 5) begin
                checks++;
                if (result_data !== 32'hDEAD_BEEF) begin
                    errors++;
                    $display("FAIL lw_result got %h want deadbeef", result_data);
                end
            end
        end
        next_cycle();
        #1;
        rv_seen = {result_valid, rv_seen[4:0]} & 6'b011111 | {1'b0, rv_seen[4:0]};
        checks++;
        if (stall_seen !== 6'b011111) begin
            errors++;
            $display("FAIL lw_stall_window got %b want 011111", stall_seen);
        end
        checks++;
        if ({result_valid, rv_seen[4:0]} !== 6'b000000 || rv_seen[5] !== 1'b0) begin
            errors++;
            $display("FAIL lw_valid_after got rv=%b cycles0-4=%b want 0 00000", result_valid, rv_seen[4:0]);
        end
    endtask

    task automatic test_loads();
        logic [7:0]  ctl [4];
        logic [31:0] a   [4];
        logic [31:0] exp [4];
        logic [1:0]  sz  [4];
        ctl = '{MC_LB, MC_LBU, MC_LH, MC_LHU};
        a   = '{32'h1003, 32'h1003, 32'h1002, 32'h1000};
        exp = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8011, 32'h0000_2233};
        sz  = '{2'd0, 2'd0, 2'd1, 2'd1};
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            valid_in = 1'b1; mem_control = ctl[i]; addr = a[i];
            next_cycle();
            data_addr_ok = 1'b1;
            #1;
            checks++;
            if ({data_req, data_size, data_addr} !== {1'b1, sz[i], a[i]}) begin
                errors++;
                $display("FAIL load%0d_request got req=%b size=%0d addr=%h want 1 %0d %h",
                         i, data_req, data_size, data_addr, sz[i], a[i]);
            end
            next_cycle();
            data_data_ok = 1'b1; data_rdata = 32'h8011_2233;
            next_cycle();
            #1;
            checks++;
            if ({result_valid, result_data} !== {1'b1, exp[i]}) begin
                errors++;
                $display("FAIL load%0d_result got valid=%b data=%h want 1 %h",
                         i, result_valid, result_data, exp[i]);
            end
        end
    endtask

    task automatic test_stores();
        logic [7:0]  ctl [3];
        logic [31:0] a   [3];
        logic [31:0] wd  [3];
        logic [31:0] ewd [3];
        logic [3:0]  ews [3];
        logic [1:0]  sz  [3];
        ctl = '{MC_SB, MC_SH, MC_SW};
        a   = '{32'h2001, 32'h2002, 32'h2000};
        wd  = '{32'h0000_00A5, 32'h1234_BEEF, 32'h1234_5678};
        ewd = '{32'hA5A5_A5A5, 32'hBEEF_BEEF, 32'h1234_5678};
        ews = '{4'b0010, 4'b1100, 4'b1111};
        sz  = '{2'd0, 2'd1, 2'd2};
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            valid_in = 1'b1; mem_control = ctl[i]; addr = a[i]; wdata = wd[i];
            next_cycle();
            #1;
            checks++;
            if ({data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata} !==
                {1'b1, 1'b1, sz[i], a[i], ews[i], ewd[i]}) begin
                errors++;
                $display("FAIL store%0d_request got req=%b wr=%b size=%0d addr=%h wstrb=%b wdata=%h want 1 1 %0d %h %b %h",
                         i, data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
                         sz[i], a[i], ews[i], ewd[i]);
            end
            data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'hFFFF_FFFF;
            next_cycle();
            #1;
            checks++;
            if ({result_valid, result_data, stall} !== {1'b1, 32'd0, 1'b0}) begin
                errors++;
                $display("FAIL store%0d_done got valid=%b data=%h stall=%b want 1 00000000 0",
                         i, result_valid, result_data, stall);
            end
        end
    endtask

    task automatic test_back_to_back();
        next_cycle();
        valid_in = 1'b1; mem_control = MC_LW; addr = 32'h4000;
        next_cycle();
        data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h55AA_1234;
        next_cycle();
        #1;
        checks++;
        if ({result_valid, result_data} !== {1'b1, 32'h55AA_1234}) begin
            errors++;
            $display("FAIL same_cycle_done got valid=%b data=%h want 1 55aa1234",
                     result_valid, result_data);
        end
    endtask

    task automatic test_reset_in_wait();
        next_cycle();
        valid_in = 1'b1; mem_control = MC_LW; addr = 32'h5000;
        next_cycle();
        data_addr_ok = 1'b1;
        next_cycle();
        #1;
        checks++;
        if ({data_req, stall} !== 2'b01) begin
            errors++;
            $display("FAIL wait_state got req=%b stall=%b want 0 1", data_req, stall);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({data_req, stall, result_valid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_in_wait got req=%b stall=%b valid=%b want 000",
                     data_req, stall, result_valid);
        end
        next_cycle();
        rst = 1'b0;
        data_data_ok = 1'b1; data_addr_ok = 1'b1; data_rdata = 32'h1111_1111;
        next_cycle();
        #1;
        checks++;
        if ({result_valid, stall, data_req} !== 3'b000) begin
            errors++;
            $display("FAIL idle_ignores_ok got valid=%b stall=%b req=%b want 000",
                     result_valid, stall, data_req);
        end
    endtask

    task automatic test_misaligned();
        next_cycle();
        valid_in = 1'b1; mem_control = MC_LW; addr = 32'h3002;
        #1;
`ifdef MEM_UNALIGNED_EXC_EN
        checks++;
        if ({adel, ades, stall} !== 3'b100) begin
            errors++;
            $display("FAIL misaligned_lw got adel=%b ades=%b stall=%b want 1 0 0", adel, ades, stall);
        end
        next_cycle();
        #1;
        checks++;
        if ({adel, data_req, stall} !== 3'b000) begin
            errors++;
            $display("FAIL misaligned_after got adel=%b req=%b stall=%b want 000", adel, data_req, stall);
        end
        valid_in = 1'b1; mem_control = MC_SH; addr = 32'h2001;
        #1;
        checks++;
        if ({adel, ades, stall} !== 3'b010) begin
            errors++;
            $display("FAIL misaligned_sh got adel=%b ades=%b stall=%b want 0 1 0", adel, ades, stall);
        end
        next_cycle();
        #1;
        checks++;
        if ({ades, data_req} !== 2'b00) begin
            errors++;
            $display("FAIL misaligned_sh_after got ades=%b req=%b want 00", ades, data_req);
        end
`else
        checks++;
        if ({adel, ades, stall} !== 3'b001) begin
            errors++;
            $display("FAIL aligned_accept got adel=%b ades=%b stall=%b want 0 0 1", adel, ades, stall);
        end
        next_cycle();
        #1;
        checks++;
        if ({data_req, data_addr} !== {1'b1, 32'h3000}) begin
            errors++;
            $display("FAIL force_align got req=%b addr=%h want 1 00003000", data_req, data_addr);
        end
        data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h1122_3344;
        next_cycle();
        #1;
        checks++;
        if (result_data !== 32'h1122_3344) begin
            errors++;
            $display("FAIL force_align_result got %h want 11223344", result_data);
        end
`endif
    endtask

    task automatic test_invalid_control();
        logic [7:0] bad [2];
        bad = '{8'b0000_1001, 8'b0000_0000};
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            valid_in = 1'b1; mem_control = bad[i]; addr = 32'h6000;
            #1;
            checks++;
            if (stall !== 1'b0) begin
                errors++;
                $display("FAIL invalid%0d_stall got %b want 0", i, stall);
            end
            next_cycle();
            #1;
            checks++;
            if ({data_req, stall} !== 2'b00) begin
                errors++;
                $display("FAIL invalid%0d_req got req=%b stall=%b want 00", i, data_req, stall);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        valid_in = 1'b0; mem_control = 8'h00; addr = '0; wdata = '0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
        test_reset();
        test_lw_latency();
        test_loads();
        test_stores();
        test_back_to_back();
        test_reset_in_wait();
        test_misaligned();
        test_invalid_control();
        next_cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
